apb4_cmd_requester: RTL and testbench

Synthesisable APB4 requester for the register-block test harness. Accepts read/write commands on a valid/ready stream, buffers them in a CMD_DEPTH-entry FIFO, and executes them one at a time as APB4 SETUP/ACCESS transfers. Each transfer returns one response carrying read data, slave error and a timeout flag.

---
 rtl/apb4_cmd_requester.sv | 203 ++++++++++++++++++++
 tb/tb_apb4_cmd_requester.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_cmd_requester.sv
// APB4 requester: buffers read/write commands in a small FIFO and executes them
// one at a time as SETUP/ACCESS transfers, returning one response per transfer.
module apb4_cmd_requester #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [DATA_WIDTH-1:0]         cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]       cmd_strb,
    input  logic [2:0]                    cmd_prot,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_slverr,
    output logic                          rsp_timeout,
    output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count,
    output logic                          busy,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [2:0]                    PPROT,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [DATA_WIDTH/8-1:0]       PSTRB,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(CMD_DEPTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH + SW + 3;
    localparam bit TO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                r_state, w_state_nxt;
    logic [EW-1:0]         r_fifo [CMD_DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_rdy_en;
    logic [TW-1:0]         r_tcnt;

    logic                  r_psel, r_penable, r_pwrite;
    logic [2:0]            r_pprot;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [SW-1:0]         r_pstrb;

    logic                  r_rsp_valid, r_rsp_write, r_rsp_slverr, r_rsp_timeout;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_full, w_empty, w_push, w_pop, w_done, w_tmo;
    logic                  w_h_write;
    logic [ADDR_WIDTH-1:0] w_h_addr;
    logic [DATA_WIDTH-1:0] w_h_wdata;
    logic [SW-1:0]         w_h_strb;
    logic [2:0]            w_h_prot;

    // r_rdy_en keeps cmd_ready low until the first edge after reset release.
    assign w_full    = (r_count == CW'(CMD_DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = r_rdy_en && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == IDLE) && !w_empty && (!r_rsp_valid || rsp_ready);
    assign {w_h_write, w_h_addr, w_h_wdata, w_h_strb, w_h_prot} = r_fifo[r_rptr];

    assign w_done = (r_state == ACCESS) && PREADY;
    // Fires in the cycle the counter would reach TIMEOUT; PREADY=1 takes priority.
    assign w_tmo  = TO_EN && (r_state == ACCESS) && !PREADY && (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (w_done || w_tmo) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tcnt <= '0;
        else if (r_state == SETUP)
            r_tcnt <= '0;
        else if ((r_state == ACCESS) && !PREADY)
            r_tcnt <= r_tcnt + TW'(1);
    end

    // Transfer register: loaded on pop, held through ACCESS, zeroed when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pprot   <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
        end else if (w_pop) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= w_h_write;
            r_pprot   <= w_h_prot;
            r_paddr   <= w_h_addr;
            r_pwdata  <= w_h_write ? w_h_wdata : '0;
            r_pstrb   <= w_h_write ? w_h_strb : '0;
        end else if (r_state == SETUP) begin
            r_penable <= 1'b1;
        end else if (w_done || w_tmo) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pprot   <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_pwrite;
            r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
            r_rsp_slverr  <= PSLVERR;
            r_rsp_timeout <= 1'b0;
        end else if (w_tmo) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_pwrite;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;
    assign cmd_count   = r_count;
    assign busy        = (r_state != IDLE) || !w_empty || r_rsp_valid;

    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PPROT   = r_pprot;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PSTRB   = r_pstrb;

endmodule

// File: tb/tb_apb4_cmd_requester.sv
// Bench for apb4_cmd_requester: directed commands, a behavioural APB slave and a
// response scoreboard fed at command acceptance and drained by a monitor.
module tb_apb4_cmd_requester;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int DEPTH = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_slverr, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [2:0]    cmd_count;
    logic          busy;
    logic          PSEL, PENABLE, PWRITE;
    logic [2:0]    PPROT;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0, PSLVERR = 1'b0;

    always #5 clk = ~clk;

    apb4_cmd_requester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .cmd_count(cmd_count), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          tmo;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Slave: PREADY after cfg_wait stalled ACCESS cycles; error on cfg_err_addr.
    int            cfg_wait = 0;
    logic [AW-1:0] cfg_err_addr = 32'hFFFF_FFFF;
    int            wcnt = 0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    always @(negedge clk) begin : slave
        logic [DW-1:0] cur;
        if (PSEL && PENABLE) begin
            PREADY  = (wcnt >= cfg_wait);
            PSLVERR = PREADY && (PADDR == cfg_err_addr);
            cur = mem.exists(PADDR) ? mem[PADDR] : '0;
            if (!PREADY)     PRDATA = 32'h5A5A_5A5A;
            else if (PWRITE) PRDATA = 32'hA5A5_A5A5;
            else             PRDATA = cur;
            if (PREADY && PWRITE) begin
                for (int b = 0; b < SW; b++)
                    if (PSTRB[b]) cur[8*b +: 8] = PWDATA[8*b +: 8];
                mem[PADDR] = cur;
            end
            wcnt++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = '0;
            wcnt    = 0;
        end
    end

    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_strb;
    int            n_setup = 0;

    always @(negedge clk) begin : proto_mon
        if (rst_n) begin
            if (PSEL && !PENABLE) begin
                n_setup++;
                cap_addr  = PADDR;
                cap_wdata = PWDATA;
                cap_strb  = PSTRB;
                if (!PWRITE) begin
                    chk("read_pstrb_zero", 64'(PSTRB), 64'd0);
                    chk("read_pwdata_zero", 64'(PWDATA), 64'd0);
                end
            end else if (PSEL && PENABLE) begin
                chk("paddr_stable", 64'(PADDR), 64'(cap_addr));
                chk("pwdata_stable", 64'(PWDATA), 64'(cap_wdata));
                chk("pstrb_stable", 64'(PSTRB), 64'(cap_strb));
            end else begin
                chk("apb_idle_zero", 64'(PENABLE | PWRITE | (|PADDR) | (|PWDATA) | (|PSTRB) | (|PPROT)), 64'd0);
            end
        end
    end

    always @(negedge clk) begin : rsp_mon
        rsp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got response rdata=0x%0h timeout=%0b, expected none", rsp_rdata, rsp_timeout);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_write", 64'(rsp_write), 64'(e.write));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_slverr", 64'(rsp_slverr), 64'(e.slverr));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] p, input bit track,
                        input logic [DW-1:0] erd, input logic es, input logic et);
        int   k = 0;
        bit   ok = 0;
        rsp_t e;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        while (!ok && k < 200) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1;
            end
            k++;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_accept: got no cmd_ready in 200 cycles, expected acceptance (addr 0x%0h)", a);
        end else if (track) begin
            e.write = w; e.rdata = erd; e.slverr = es; e.tmo = et;
            exp_q.push_back(e);
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic measure(output int lat, output int acc);
        lat = 0;
        acc = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (PENABLE) acc++;
            if (rsp_valid) break;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || rsp_valid) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, acc, s0, k;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_psel", 64'(PSEL), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_cmd_count", 64'(cmd_count), 64'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("release_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        chk("release_cmd_ready_high", 64'(cmd_ready), 64'd1);

        // Zero-wait write: cycle-by-cycle phases.
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010, 1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("wr_c1_psel", 64'(PSEL), 64'd0);
        @(negedge clk);
        chk("wr_c2_psel", 64'(PSEL), 64'd1);
        chk("wr_c2_penable", 64'(PENABLE), 64'd0);
        chk("wr_c2_pwrite", 64'(PWRITE), 64'd1);
        chk("wr_c2_paddr", 64'(PADDR), 64'h10);
        chk("wr_c2_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
        chk("wr_c2_pstrb", 64'(PSTRB), 64'hF);
        chk("wr_c2_pprot", 64'(PPROT), 64'd2);
        @(negedge clk);
        chk("wr_c3_psel", 64'(PSEL), 64'd1);
        chk("wr_c3_penable", 64'(PENABLE), 64'd1);
        @(negedge clk);
        chk("wr_c4_rsp_valid", 64'(rsp_valid), 64'd1);
        drain();

        send(1'b0, 32'h10, 32'h1234_5678, 4'hF, 3'b000, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        measure(lat, acc);
        chk("rd_latency", 64'(lat), 64'd4);
        chk("rd_access_cycles", 64'(acc), 64'd1);
        drain();

        // Three wait states; partial strobes.
        cfg_wait = 3;
        send(1'b1, 32'h30, 32'h1234_5678, 4'b0011, 3'b001, 1, 32'h0, 1'b0, 1'b0);
        measure(lat, acc);
        chk("wait_wr_latency", 64'(lat), 64'd7);
        chk("wait_wr_access_cycles", 64'(acc), 64'd4);
        drain();
        send(1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 1, 32'h0000_5678, 1'b0, 1'b0);
        measure(lat, acc);
        chk("wait_rd_latency", 64'(lat), 64'd7);
        drain();

        // Timeout with PREADY stuck low, then PREADY on the 16th ACCESS cycle.
        cfg_wait = 1000;
        send(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1, 32'h0, 1'b1, 1'b1);
        measure(lat, acc);
        chk("tmo_latency", 64'(lat), 64'd19);
        chk("tmo_access_cycles", 64'(acc), 64'd16);
        chk("tmo_psel_dropped", 64'(PSEL), 64'd0);
        drain();
        cfg_wait = 15;
        send(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        measure(lat, acc);
        chk("edge_tmo_latency", 64'(lat), 64'd19);
        chk("edge_tmo_access_cycles", 64'(acc), 64'd16);
        drain();

        // Slave error followed by a queued read.
        cfg_wait = 0;
        cfg_err_addr = 32'h20;
        send(1'b1, 32'h20, 32'h1111_1111, 4'hF, 3'b000, 1, 32'h0, 1'b1, 1'b0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        drain();
        cfg_err_addr = 32'hFFFF_FFFF;

        // Backpressure: six commands with rsp_ready low.
        rsp_ready = 1'b0;
        s0 = n_setup;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(1'b1, 32'h100 + 32'(4 * i), 32'hCAFE_0000 + 32'(i), 4'hF, 3'b000, 1, 32'h0, 1'b0, 1'b0);
                send(1'b0, 32'h104, 32'h0, 4'h0, 3'b000, 1, 32'hCAFE_0001, 1'b0, 1'b0);
                send(1'b0, 32'h10C, 32'h0, 4'h0, 3'b000, 1, 32'hCAFE_0003, 1'b0, 1'b0);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                chk("bp_cmd_count_full", 64'(cmd_count), 64'd4);
                chk("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
                chk("bp_single_transfer", 64'(n_setup - s0), 64'd1);
                chk("bp_rsp_held", 64'(rsp_valid), 64'd1);
                chk("bp_busy", 64'(busy), 64'd1);
                rsp_ready = 1'b1;
            end
        join
        drain();
        chk("bp_all_transfers", 64'(n_setup - s0), 64'd6);

        // Asynchronous reset in the middle of ACCESS.
        cfg_wait = 1000;
        send(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 0, 32'h0, 1'b0, 1'b0);
        send(1'b1, 32'h44, 32'h7777_7777, 4'hF, 3'b000, 0, 32'h0, 1'b0, 1'b0);
        k = 0;
        while (!PENABLE && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("pre_reset_penable", 64'(PENABLE), 64'd1);
        chk("pre_reset_cmd_count", 64'(cmd_count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_psel", 64'(PSEL), 64'd0);
        chk("async_rst_penable", 64'(PENABLE), 64'd0);
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_cmd_count", 64'(cmd_count), 64'd0);
        chk("async_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        repeat (2) @(posedge clk);
        cfg_wait = 0;
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst2_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        chk("rst2_cmd_ready_high", 64'(cmd_ready), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("rst2_no_dropped_rsp", 64'(rsp_valid), 64'd0);
        chk("rst2_idle_busy", 64'(busy), 64'd0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        measure(lat, acc);
        chk("rst2_rd_latency", 64'(lat), 64'd4);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
